sprite_plotter: RTL and testbench

SPRITE_PLOTTER -- requirements
Module: sprite_plotter

---
 rtl/sprite_plotter.sv | 98 +++++++++
 tb/tb_sprite_plotter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/sprite_plotter.sv
// Square sprite plotter: scans a SIZE x SIZE block row-major from a
// latched top-left corner, emitting one VGA pixel write per cycle.
module sprite_plotter #(
   parameter int unsigned SIZE = 4,
   parameter logic [2:0] FG_COLOUR = 3'b111,
   parameter logic [2:0] BG_COLOUR = 3'b000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       s_color,
   input  logic [7:0] xpos,
   input  logic [6:0] ypos,
   output logic       busy,
   output logic       done,
   output logic [7:0] vga_x,
   output logic [6:0] vga_y,
   output logic [2:0] vga_colour,
   output logic       vga_plot
);

   localparam int unsigned CW = $clog2(SIZE);
   localparam logic [CW-1:0] LAST = CW'(SIZE - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DRAW = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state;
   logic [7:0]    x0;
   logic [6:0]    y0;
   logic [2:0]    col;
   logic [CW-1:0] cx;
   logic [CW-1:0] cy;
   logic [8:0]    sx;
   logic [7:0]    sy;
   logic          clip;

   // Sequencer: latch the request in IDLE, scan row-major in DRAW,
   // one DONE cycle, then back to IDLE. Latched values are frozen
   // until the next accepted start.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         x0    <= '0;
         y0    <= '0;
         col   <= BG_COLOUR;
         cx    <= '0;
         cy    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  x0    <= xpos;
                  y0    <= ypos;
                  col   <= s_color ? FG_COLOUR : BG_COLOUR;
                  cx    <= '0;
                  cy    <= '0;
                  state <= DRAW;
               end
            end
            DRAW: begin
               if (cx == LAST) begin
                  cx <= '0;
                  if (cy == LAST) begin
                     cy    <= '0;
                     state <= DONE;
                  end else begin
                     cy <= cy + 1'b1;
                  end
               end else begin
                  cx <= cx + 1'b1;
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Wide sums so pixels falling off the right/bottom edge are detected
   // rather than wrapping back onto the screen.
   always_comb begin
      sx   = {1'b0, x0} + 9'(cx);
      sy   = {1'b0, y0} + 8'(cy);
      clip = (sx > 9'd159) || (sy > 8'd119);
   end

   assign busy       = (state == DRAW);
   assign done       = (state == DONE);
   assign vga_x      = busy ? sx[7:0] : x0;
   assign vga_y      = busy ? sy[6:0] : y0;
   assign vga_colour = col;
   assign vga_plot   = busy && !clip;

endmodule

// File: tb/tb_sprite_plotter.sv
// Directed bench for sprite_plotter: table of sprite requests with
// hand-computed plot counts, plus reset/abort corner sequences.
module tb_sprite_plotter;

   localparam int SZ = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       s_color = 1'b0;
   logic [7:0] xpos = '0;
   logic [6:0] ypos = '0;
   logic       busy;
   logic       done;
   logic [7:0] vga_x;
   logic [6:0] vga_y;
   logic [2:0] vga_colour;
   logic       vga_plot;

   int checks = 0;
   int errors = 0;

   sprite_plotter dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .s_color(s_color),
      .xpos(xpos),
      .ypos(ypos),
      .busy(busy),
      .done(done),
      .vga_x(vga_x),
      .vga_y(vga_y),
      .vga_colour(vga_colour),
      .vga_plot(vga_plot)
   );

   always #5 clk = ~clk;

   typedef struct {
      int x;
      int y;
      bit c;
      int nplot;
      int col;
      bit repulse;
   } vec_t;

   vec_t v[7];

   task automatic chk(input string nm, input logic [15:0] act,
                      input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0d want %0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one sprite and check every DRAW cycle against a small model.
   task automatic run_sprite(input vec_t t);
      int np;
      int nb;
      int ex;
      int ey;
      bit ep;
      np = 0;
      nb = 0;
      xpos = t.x[7:0];
      ypos = t.y[6:0];
      s_color = t.c;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < SZ * SZ; i++) begin
         ex = t.x + (i % SZ);
         ey = t.y + (i / SZ);
         ep = (ex < 160) && (ey < 120);
         chk("draw_busy", 16'(busy), 16'd1);
         chk("draw_done", 16'(done), 16'd0);
         chk("draw_x", 16'(vga_x), 16'(ex & 8'hff));
         chk("draw_y", 16'(vga_y), 16'(ey & 7'h7f));
         chk("draw_plot", 16'(vga_plot), 16'(ep));
         chk("draw_col", 16'(vga_colour), 16'(t.col));
         if (vga_plot) np++;
         if (busy) nb++;
         if (t.repulse) begin
            start = (i == 4);
            xpos = 8'd50;
            ypos = 7'd5;
            s_color = ~t.c;
         end
         tick();
      end
      start = 1'b0;
      chk("plot_count", 16'(np), 16'(t.nplot));
      chk("busy_count", 16'(nb), 16'(SZ * SZ));
      chk("done_pulse", 16'(done), 16'd1);
      chk("done_busy", 16'(busy), 16'd0);
      chk("done_plot", 16'(vga_plot), 16'd0);
      chk("done_x", 16'(vga_x), 16'(t.x));
      tick();
      chk("idle_done", 16'(done), 16'd0);
      chk("idle_busy", 16'(busy), 16'd0);
      chk("idle_plot", 16'(vga_plot), 16'd0);
      chk("idle_x", 16'(vga_x), 16'(t.x));
      chk("idle_y", 16'(vga_y), 16'(t.y));
      chk("idle_col", 16'(vga_colour), 16'(t.col));
   endtask

   initial begin
      int seen_done;
      int seen_plot;
      v[0] = '{10, 20, 1'b1, 16, 7, 1'b0};
      v[1] = '{0, 0, 1'b0, 16, 0, 1'b0};
      v[2] = '{158, 118, 1'b1, 4, 7, 1'b0};
      v[3] = '{159, 119, 1'b0, 1, 0, 1'b0};
      v[4] = '{156, 116, 1'b1, 16, 7, 1'b0};
      v[5] = '{150, 117, 1'b1, 12, 7, 1'b0};
      v[6] = '{30, 40, 1'b1, 16, 7, 1'b1};

      tick();
      tick();
      chk("rst_busy", 16'(busy), 16'd0);
      chk("rst_done", 16'(done), 16'd0);
      chk("rst_plot", 16'(vga_plot), 16'd0);
      chk("rst_x", 16'(vga_x), 16'd0);
      chk("rst_y", 16'(vga_y), 16'd0);
      chk("rst_col", 16'(vga_colour), 16'd0);
      reset = 1'b0;
      tick();

      for (int k = 0; k < 7; k++) begin
         run_sprite(v[k]);
         tick();
      end

      // Abort in the fifth DRAW cycle.
      xpos = 8'd70;
      ypos = 7'd60;
      s_color = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      chk("abort_pre_busy", 16'(busy), 16'd1);
      chk("abort_pre_x", 16'(vga_x), 16'd70);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("abort_busy", 16'(busy), 16'd0);
      chk("abort_plot", 16'(vga_plot), 16'd0);
      chk("abort_x", 16'(vga_x), 16'd0);
      chk("abort_col", 16'(vga_colour), 16'd0);
      seen_done = 0;
      seen_plot = 0;
      for (int i = 0; i < 20; i++) begin
         if (done) seen_done++;
         if (vga_plot) seen_plot++;
         tick();
      end
      chk("abort_no_done", 16'(seen_done), 16'd0);
      chk("abort_no_plot", 16'(seen_plot), 16'd0);
      run_sprite(v[0]);
      tick();

      // Reset and start on the same edge.
      xpos = 8'd90;
      ypos = 7'd90;
      start = 1'b1;
      reset = 1'b1;
      tick();
      start = 1'b0;
      reset = 1'b0;
      chk("same_busy", 16'(busy), 16'd0);
      chk("same_x", 16'(vga_x), 16'd0);
      seen_plot = 0;
      for (int i = 0; i < 5; i++) begin
         if (vga_plot || busy) seen_plot++;
         tick();
      end
      chk("same_no_plot", 16'(seen_plot), 16'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
